hilo_div_ctrl: RTL and testbench
================================

# hilo_div_ctrl

Multi-cycle division sequencer that owns the DIV/DIVU write path into the HI/LO register pair. It accepts a divide request from the EX stage and stalls the pipeline while it runs a 32-iteration radix-2 restoring division. On completion it presents remainder and quotient with a one-cycle write strobe for HI/LO. It also handles divide-by-zero, signed correction, and cancellation on pipeline flush.

## Interface
- No parameters; data width fixed at 32 bits.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  divide request, sampled only in FREE.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
- opdata1_i  in  32  dividend; sampled with start_i.
- opdata2_i  in  32  divisor; sampled with start_i.
- annul_i  in  1  flush; cancels an operation in progress.
- stallreq_o  out  1  pipeline stall request (combinational).
- busy_o  out  1  state != FREE (registered state decode).
- ready_o  out  1  result valid pulse.
- whilo_o  out  1  HI/LO write enable, identical to ready_o.
- hi_o  out  32  remainder, held until the next completion.
- lo_o  out  32  quotient, held until the next completion.

## Operation
- States:
  - FREE: idle.
  - SHORT: one-cycle path for zero divisor or early-out.
  - ON: iterating.
  - END: result cycle.
- FREE:
  - If start_i=1 and annul_i=0, latch |dividend|, |divisor|, sign flags, signed_i and the original dividend, and clear the iteration counter.
  - If divisor==0, go to SHORT; otherwise go to ON.
  - If start_i=0, or start_i=1 with annul_i=1, stay in FREE.
- ON:
  - Each cycle, shift the 65-bit partial-remainder/quotient register left by one and trial-subtract the divisor.
  - On non-negative, keep the difference and set quotient bit 1; otherwise restore and set 0.
  - The counter increments 0..31; after the iteration with counter==31, go to END.
- SHORT: go to END next cycle.
  - Divide-by-zero result: hi=0, lo=0.
- END:
  - ready_o=1 and whilo_o=1 for exactly one cycle.
  - hi_o/lo_o are loaded at the edge entering END.
  - END always returns to FREE; no back-to-back start is accepted in END.
- Signed correction (signed_i=1):
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wrap, no trap).
- annul_i=1 in ON or SHORT: go to FREE at the next edge. No ready_o pulse; hi_o/lo_o unchanged.
- annul_i in END is ignored; the write completes.
- start_i while busy is ignored; the requester keeps it asserted because stallreq_o holds the pipeline.
- stallreq_o = (FREE & start_i & ~annul_i) | ON | SHORT; it is 0 in END.

## Timing
- Reset: state FREE, counter 0, all outputs 0 (stallreq_o=0, busy_o=0, ready_o=0, whilo_o=0, hi_o=0, lo_o=0).
- Reset asserted mid-operation aborts immediately; there is no write pulse after release.
- Normal divide, with start_i high in cycle T:
  - ON for T+1..T+32.
  - END in T+33, with ready_o/whilo_o high in T+33 only.
  - stallreq_o high in T..T+32.
- SHORT path: SHORT in T+1, END in T+2, stallreq_o high in T..T+1.
- The earliest next accepted start is T+34 (normal) or T+3 (short).
- hi_o/lo_o are registered outputs with no combinational path from inputs.

## Configuration
- HILO_DIV_EARLY_OUT_EN defined:
  - In FREE, if the divisor is nonzero and |dividend| < |divisor| (unsigned compare of magnitudes), take SHORT.
  - Result: lo=0, hi=original dividend, which is already sign-correct.
  - Latency matches the zero-divisor case.
- Undefined:
  - Only divisor==0 takes SHORT.
  - All other divides take the full 33 cycles.
  - Results are identical either way.

## Test plan
- DIVU 100/7, start at T → ready_o/whilo_o high only at T+33, hi_o=2, lo_o=14; stallreq_o high exactly T..T+32.
- DIV 0xFFFFFF9C (-100) / 7 → lo_o=0xFFFFFFF2 (-14), hi_o=0xFFFFFFFE (-2); DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- DIVU 5/0 → END at T+2, hi_o=0, lo_o=0, one whilo_o pulse.
- DIVU 123/456:
  - With HILO_DIV_EARLY_OUT_EN: ready at T+2, hi_o=123, lo_o=0.
  - Without: ready at T+33, same values.
- annul_i pulsed at T+10 of a running divide → FREE at T+11, no ready_o, hi_o/lo_o keep prior values. A new start at T+11 completes normally at T+44.
- rst driven low asynchronously at T+20 → all outputs 0 immediately. After release, a fresh DIVU 9/3 yields hi_o=0, lo_o=3 at 33 cycles after its start.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer owning the HI/LO write path (32-step radix-2 restoring divide).
// Latency: 33 cycles from accepted start to the write strobe; 2 cycles for zero divisor / early-out.
// Backpressure: stallreq_o holds the pipeline while busy; define HILO_DIV_EARLY_OUT_EN for |a|<|b| early-out.
module hilo_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic        stallreq_o,
    output logic        busy_o,
    output logic        ready_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_ON    = 2'd2,
        ST_END   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [63:0] rq;
    logic [63:0] rq_nxt;
    logic [31:0] dvs;
    logic        neg_q, neg_r;
    logic [31:0] abs_a, abs_b;
    logic        accept, take_short;
    logic [32:0] sh_hi, trial;
    logic [31:0] quot_fix, rem_fix;

    assign abs_a  = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign abs_b  = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    assign accept = start_i && !annul_i;

`ifdef HILO_DIV_EARLY_OUT_EN
    logic [31:0] orig_a;
    logic        short_zero;
    // |a| < |b| means quotient 0 and remainder equal to the untouched dividend.
    assign take_short = (opdata2_i == 32'd0) || (abs_a < abs_b);
`else
    assign take_short = (opdata2_i == 32'd0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FREE:  if (accept) state_nxt = take_short ? ST_SHORT : ST_ON;
            ST_SHORT: state_nxt = annul_i ? ST_FREE : ST_END;
            ST_ON: begin
                if (annul_i)
                    state_nxt = ST_FREE;
                else if (cnt == 5'd31)
                    state_nxt = ST_END;
            end
            ST_END:   state_nxt = ST_FREE;
            default:  state_nxt = ST_FREE;
        endcase
    end

    // rq holds {partial remainder, quotient/dividend}; the shifted-out top bit joins the trial subtract.
    always_comb begin
        sh_hi  = rq[63:31];
        trial  = sh_hi - {1'b0, dvs};
        rq_nxt = {sh_hi[31:0], rq[30:0], 1'b0};
        if (!trial[32])
            rq_nxt = {trial[31:0], rq[30:0], 1'b1};
        quot_fix = neg_q ? (~rq_nxt[31:0] + 32'd1) : rq_nxt[31:0];
        rem_fix  = neg_r ? (~rq_nxt[63:32] + 32'd1) : rq_nxt[63:32];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FREE;
            cnt   <= 5'd0;
            rq    <= 64'd0;
            dvs   <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_o  <= 32'd0;
            lo_o  <= 32'd0;
`ifdef HILO_DIV_EARLY_OUT_EN
            orig_a     <= 32'd0;
            short_zero <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                ST_FREE: begin
                    if (accept) begin
                        rq    <= {32'd0, abs_a};
                        dvs   <= abs_b;
                        neg_q <= signed_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r <= signed_i && opdata1_i[31];
                        cnt   <= 5'd0;
`ifdef HILO_DIV_EARLY_OUT_EN
                        orig_a     <= opdata1_i;
                        short_zero <= (opdata2_i == 32'd0);
`endif
                    end
                end
                ST_ON: begin
                    if (!annul_i) begin
                        rq  <= rq_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            hi_o <= rem_fix;
                            lo_o <= quot_fix;
                        end
                    end
                end
                ST_SHORT: begin
                    if (!annul_i) begin
`ifdef HILO_DIV_EARLY_OUT_EN
                        hi_o <= short_zero ? 32'd0 : orig_a;
`else
                        hi_o <= 32'd0;
`endif
                        lo_o <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = (state != ST_FREE);
    assign ready_o    = (state == ST_END);
    assign whilo_o    = ready_o;
    assign stallreq_o = ((state == ST_FREE) && accept) || (state == ST_ON) || (state == ST_SHORT);

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: vector table plus annul and mid-operation reset sequences.
module tb_hilo_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, signed_i, annul_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        stallreq_o, busy_o, ready_o, whilo_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hilo_div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .stallreq_o (stallreq_o),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        eo;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input vec_t v);
        if (v.b == 32'd0) return 2;
`ifdef HILO_DIV_EARLY_OUT_EN
        if (v.eo) return 2;
`endif
        return 33;
    endfunction

    // Entered #1 after a rising edge; start is held while the stall is expected.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int rdy_at, rdy_cnt, stall_bad, whilo_bad;
        lat = lat_of(v);
        rdy_at = -1; rdy_cnt = 0; stall_bad = 0; whilo_bad = 0;
        start_i = 1'b1; signed_i = v.sgn; opdata1_i = v.a; opdata2_i = v.b; annul_i = 1'b0;
        for (int k = 0; k <= lat + 1; k++) begin
            @(negedge clk);
            if (ready_o) begin
                rdy_cnt++;
                if (rdy_at < 0) rdy_at = k;
            end
            if (whilo_o !== ready_o) whilo_bad++;
            if (stallreq_o !== (k < lat)) stall_bad++;
            if (k == lat) begin
                chk({tag, " hi"}, hi_o, v.hi);
                chk({tag, " lo"}, lo_o, v.lo);
            end
            @(posedge clk); #1;
            if (k + 1 >= lat) start_i = 1'b0;
        end
        chk({tag, " ready_cycle"}, 32'(rdy_at), 32'(lat));
        chk({tag, " ready_count"}, 32'(rdy_cnt), 32'd1);
        chk({tag, " stall_pattern_errs"}, 32'(stall_bad), 32'd0);
        chk({tag, " whilo_vs_ready_errs"}, 32'(whilo_bad), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stallreq"}, {31'd0, stallreq_o}, 32'd0);
        chk({tag, " busy"},     {31'd0, busy_o},     32'd0);
        chk({tag, " ready"},    {31'd0, ready_o},    32'd0);
        chk({tag, " whilo"},    {31'd0, whilo_o},    32'd0);
        chk({tag, " hi"},       hi_o,                32'd0);
        chk({tag, " lo"},       lo_o,                32'd0);
    endtask

    initial begin
        int early, held_bad;
        logic [31:0] ph, pl;
        vec_t v93;

        //          sgn   a             b             hi            lo            eo
        vecs[0]  = '{1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
        vecs[2]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[3]  = '{1'b0, 32'd5,        32'd0,        32'd0,        32'd0,        1'b0};
        vecs[4]  = '{1'b0, 32'd123,      32'd456,      32'd123,      32'd0,        1'b1};
        vecs[5]  = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0};
        vecs[6]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0};
        vecs[9]  = '{1'b1, 32'd5,        32'd0,        32'd0,        32'd0,        1'b0};
        vecs[10] = '{1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFD, 32'd0,        1'b1};
        vecs[11] = '{1'b0, 32'h80000000, 32'h80000001, 32'h80000000, 32'd0,        1'b1};
        vecs[12] = '{1'b0, 32'hDEADBEEF, 32'h00001234, 32'h0000076B, 32'h000C3BA5, 1'b0};

        rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Annul a running divide at cycle 10, restart at cycle 11, expect write at 44.
        ph = vecs[NV-1].hi; pl = vecs[NV-1].lo;
        early = 0; held_bad = 0;
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd10; annul_i = 1'b0;
        for (int k = 0; k <= 45; k++) begin
            @(negedge clk);
            if (k < 44) begin
                if (ready_o) early++;
                if (hi_o !== ph || lo_o !== pl) held_bad++;
            end
            if (k == 10) chk("annul stall_in_on", {31'd0, stallreq_o}, 32'd1);
            if (k == 11) begin
                chk("annul busy_after", {31'd0, busy_o}, 32'd0);
                chk("annul restart_stall", {31'd0, stallreq_o}, 32'd1);
            end
            if (k == 44) begin
                chk("annul restart_ready", {31'd0, ready_o}, 32'd1);
                chk("annul restart_hi", hi_o, 32'd0);
                chk("annul restart_lo", lo_o, 32'd11);
            end
            if (k == 45) chk("annul ready_drop", {31'd0, ready_o}, 32'd0);
            @(posedge clk); #1;
            if (k + 1 == 10) annul_i = 1'b1;
            if (k + 1 == 11) begin
                annul_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd7;
            end
            if (k + 1 == 44) start_i = 1'b0;
        end
        chk("annul early_ready_count", 32'(early), 32'd0);
        chk("annul held_hilo_errs", 32'(held_bad), 32'd0);

        // Asynchronous reset in the middle of a divide.
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd10;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        early = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ready_o) early++;
            @(posedge clk); #1;
        end
        chk("midreset no_ready_after_release", 32'(early), 32'd0);
        v93 = '{1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0};
        run_vec(v93, "after_reset_9_3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
